// File: rtl/a2s_pkg.sv
// rtl/a2s_pkg.sv - shared constants and handshake state type for the async-to-sync receiver
// Contents:
//   A2S_DW       default data word width
//   a2s_state_e  handshake FSM state (IDLE: So=0, ACK: So=1)
package a2s_pkg;

    localparam int A2S_DW = 64;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } a2s_state_e;

endpackage

// File: rtl/a2s_rx_fifo.sv
// rtl/a2s_rx_fifo.sv - first-word-fall-through FIFO behind the async-to-sync receiver
// Parameters: DW word width, DEPTH words (power of 2, >= 2)
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push, din, full write side; a push is ignored while full
//   pop, dout, empty read side; dout is the head word, zero while empty
//   level           words stored, wr_ptr - rd_ptr
module a2s_rx_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    output logic                     full,
    input  logic                     pop,
    output logic [DW-1:0]            dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are unobservable until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/a2s_sync_rx.sv
// rtl/a2s_sync_rx.sv - receive side of a 4-phase async-to-sync bridge with FWFT output FIFO
// Parameters: DW word width, DEPTH FIFO words (power of 2, >= 2), SYNC_STAGES (>= 2)
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   Si, Din           asynchronous request and bundled data from the sender
//   So                registered acknowledge back to the sender
//   m_data, m_valid   FIFO head word and its valid flag
//   m_ready           consumer accept; pop on m_valid && m_ready
//   fifo_level        words stored
//   token_count       pushes since reset, wrapping (only with A2S_RX_TOKEN_COUNT_EN)
module a2s_sync_rx
    import a2s_pkg::*;
#(
    parameter int DW          = A2S_DW,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     Si,
    input  logic [DW-1:0]            Din,
    output logic                     So,
    output logic [DW-1:0]            m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef A2S_RX_TOKEN_COUNT_EN
    ,
    output logic [31:0]              token_count
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   si_s;
    a2s_state_e             state_q;
    a2s_state_e             state_d;
    logic                   push;
    logic                   full;
    logic                   empty;

    always_ff @(posedge CLK) begin
        if (RESET) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], Si};
    end
    assign si_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Holding IDLE while full withholds So, which stalls the sender.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (si_s && !full) begin
                    state_d = ACK;
                    push    = 1'b1;
                end
            end
            ACK: begin
                if (!si_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign So      = (state_q == ACK);
    assign m_valid = !empty;

    a2s_rx_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .reset (RESET),
        .push  (push),
        .din   (Din),
        .full  (full),
        .pop   (m_ready),
        .dout  (m_data),
        .empty (empty),
        .level (fifo_level)
    );

`ifdef A2S_RX_TOKEN_COUNT_EN
    always_ff @(posedge CLK) begin
        if (RESET)     token_count <= '0;
        else if (push) token_count <= token_count + 32'd1;
    end
`endif

endmodule
